// File: rtl/wishbone_arb_bus.sv
// -----------------------------------------------------------------------------
// wishbone_arb_bus
//
// Shared Wishbone bus: M masters arbitrate for a single path that is
// replicated to S slaves. The slave is chosen by an external address decoder
// (s_sel_one_hot, fed from m_grant_addr).
//
// Grant g is a registered one-hot vector (all-zero = idle). The granted
// master keeps the bus while its cyc stays high. When it drops cyc, g reloads
// on the next edge with the arbiter result. Arbitration is either round-robin
// (ARB_MODE=0) or fixed priority with index 0 highest (ARB_MODE=1).
//
// Optional feature: define WISHBONE_ARB_BUS_TIMEOUT_EN to add a watchdog.
// The watchdog raises err and bus_timeout_o after TIMEOUT unterminated
// strobe cycles.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   m_*_i_all                       flattened master requests (master i = slice i)
//   m_dat_o_all                     read data broadcast to every master
//   m_ack/err/rty_o_all             per-master terminations (granted master only)
//   s_*_o_all                       granted-master fields replicated per slave
//   s_dat_i_all, s_ack/err/rty_i_all slave responses
//   s_sel_one_hot                   external decode of m_grant_addr
//   m_grant_addr, snoop_adr_o       granted master address
//   snoop_en_o                      slave ack on a granted write
//   bus_timeout_o                   one-cycle watchdog expiry pulse
//   arb_state_o                     debug: 1 = OWNED, 0 = IDLE
//
// Handshake: a slave transfer is requested while stb & cyc of the granted
// master are high and the slave's s_stb bit is set. It completes in any
// cycle where a slave asserts ack, err or rty. All asserted terminations pass
// through together, with no priority between them.
// -----------------------------------------------------------------------------
module wishbone_arb_bus #(
  parameter int M        = 4,
  parameter int S        = 4,
  parameter int Dw       = 32,
  parameter int Aw       = 32,
  parameter int SELw     = 4,
  parameter int TAGw     = 3,
  parameter int CTIw     = 3,
  parameter int BTEw     = 2,
  parameter int ARB_MODE = 0,
  parameter int TOw      = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [M*Aw-1:0]   m_adr_i_all,
  input  logic [M*Dw-1:0]   m_dat_i_all,
  input  logic [M*SELw-1:0] m_sel_i_all,
  input  logic [M*TAGw-1:0] m_tag_i_all,
  input  logic [M*CTIw-1:0] m_cti_i_all,
  input  logic [M*BTEw-1:0] m_bte_i_all,
  input  logic [M-1:0]      m_we_i_all,
  input  logic [M-1:0]      m_stb_i_all,
  input  logic [M-1:0]      m_cyc_i_all,
  output logic [M*Dw-1:0]   m_dat_o_all,
  output logic [M-1:0]      m_ack_o_all,
  output logic [M-1:0]      m_err_o_all,
  output logic [M-1:0]      m_rty_o_all,
  output logic [S*Aw-1:0]   s_adr_o_all,
  output logic [S*Dw-1:0]   s_dat_o_all,
  output logic [S*SELw-1:0] s_sel_o_all,
  output logic [S*TAGw-1:0] s_tag_o_all,
  output logic [S*CTIw-1:0] s_cti_o_all,
  output logic [S*BTEw-1:0] s_bte_o_all,
  output logic [S-1:0]      s_we_o_all,
  output logic [S-1:0]      s_cyc_o_all,
  output logic [S-1:0]      s_stb_o_all,
  input  logic [S*Dw-1:0]   s_dat_i_all,
  input  logic [S-1:0]      s_ack_i_all,
  input  logic [S-1:0]      s_err_i_all,
  input  logic [S-1:0]      s_rty_i_all,
  input  logic [S-1:0]      s_sel_one_hot,
  output logic [Aw-1:0]     m_grant_addr,
  output logic [Aw-1:0]     snoop_adr_o,
  output logic              snoop_en_o,
  output logic              bus_timeout_o,
  output logic              arb_state_o
);

  logic [M-1:0] g;

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  if (M == 1) begin : g_single
    // A lone master owns the bus whenever it asserts cyc.
    assign g           = m_cyc_i_all;
    assign arb_state_o = m_cyc_i_all[0];
  end else begin : g_arb
    localparam int PW = $clog2(M);
    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_t;

    arb_state_t   state_q, state_d;
    logic [M-1:0] g_q, g_d, arb_g;
    logic [PW-1:0] ptr_q, ptr_d, ptr_win;
    logic         found;
    int           rr_idx;

    // Winner among current cyc requesters. ptr_q is the first index examined.
    always_comb begin
      arb_g   = '0;
      found   = 1'b0;
      ptr_win = ptr_q;
      rr_idx  = 0;
      if (ARB_MODE == 1) begin
        // Scan downwards so the lowest requesting index is left last.
        for (int i = M - 1; i >= 0; i--) begin
          if (m_cyc_i_all[i]) begin
            arb_g    = '0;
            arb_g[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < M; k++) begin
          rr_idx = (int'(ptr_q) + k) % M;
          if (!found && m_cyc_i_all[rr_idx]) begin
            arb_g[rr_idx] = 1'b1;
            found         = 1'b1;
            ptr_win       = PW'((rr_idx + 1) % M);
          end
        end
      end
    end

    always_comb begin
      g_d     = g_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
        IDLE: begin
          if (found) begin
            g_d     = arb_g;
            state_d = OWNED;
            ptr_d   = ptr_win;
          end
        end
        OWNED: begin
          // Owner released cyc: hand over (or go idle) on this edge.
          if ((g_q & m_cyc_i_all) == '0) begin
            g_d     = arb_g;
            state_d = found ? OWNED : IDLE;
            ptr_d   = found ? ptr_win : ptr_q;
          end
        end
        default: begin
          g_d     = '0;
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        g_q     <= '0;
        state_q <= IDLE;
        ptr_q   <= '0;
      end else begin
        g_q     <= g_d;
        state_q <= state_d;
        ptr_q   <= ptr_d;
      end
    end

    assign g           = g_q;
    assign arb_state_o = (state_q == OWNED);
  end

  // ---------------------------------------------------------------------------
  // Granted-master field mux (AND-OR on the one-hot grant; zero when idle)
  // ---------------------------------------------------------------------------
  logic [Aw-1:0]   gnt_adr;
  logic [Dw-1:0]   gnt_dat;
  logic [SELw-1:0] gnt_sel;
  logic [TAGw-1:0] gnt_tag;
  logic [CTIw-1:0] gnt_cti;
  logic [BTEw-1:0] gnt_bte;
  logic            gnt_we, gnt_stb, gnt_cyc;

  always_comb begin
    gnt_adr = '0;
    gnt_dat = '0;
    gnt_sel = '0;
    gnt_tag = '0;
    gnt_cti = '0;
    gnt_bte = '0;
    gnt_we  = 1'b0;
    gnt_stb = 1'b0;
    gnt_cyc = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (g[i]) begin
        gnt_adr = gnt_adr | m_adr_i_all[i*Aw +: Aw];
        gnt_dat = gnt_dat | m_dat_i_all[i*Dw +: Dw];
        gnt_sel = gnt_sel | m_sel_i_all[i*SELw +: SELw];
        gnt_tag = gnt_tag | m_tag_i_all[i*TAGw +: TAGw];
        gnt_cti = gnt_cti | m_cti_i_all[i*CTIw +: CTIw];
        gnt_bte = gnt_bte | m_bte_i_all[i*BTEw +: BTEw];
        gnt_we  = gnt_we  | m_we_i_all[i];
        gnt_stb = gnt_stb | m_stb_i_all[i];
        gnt_cyc = gnt_cyc | m_cyc_i_all[i];
      end
    end
  end

  logic active;
  assign active = gnt_stb & gnt_cyc;

  assign s_adr_o_all = {S{gnt_adr}};
  assign s_dat_o_all = {S{gnt_dat}};
  assign s_sel_o_all = {S{gnt_sel}};
  assign s_tag_o_all = {S{gnt_tag}};
  assign s_cti_o_all = {S{gnt_cti}};
  assign s_bte_o_all = {S{gnt_bte}};
  assign s_we_o_all  = {S{gnt_we}};
  assign s_cyc_o_all = {S{gnt_cyc}};
  assign s_stb_o_all = s_sel_one_hot & {S{active}};

  assign m_grant_addr = gnt_adr;
  assign snoop_adr_o  = gnt_adr;

  // ---------------------------------------------------------------------------
  // Read data return
  // ---------------------------------------------------------------------------
  logic [Dw-1:0] rd_dat;

  always_comb begin
    rd_dat = '0;
    for (int j = 0; j < S; j++) begin
      if (s_sel_one_hot[j]) rd_dat = rd_dat | s_dat_i_all[j*Dw +: Dw];
    end
  end

  assign m_dat_o_all = {M{rd_dat}};

  // ---------------------------------------------------------------------------
  // Terminations, decode error, snoop
  // ---------------------------------------------------------------------------
  logic any_ack, any_err, any_rty;
  logic dec_err_q;
  logic timeout_hit;

  assign any_ack = |s_ack_i_all;
  assign any_err = |s_err_i_all;
  assign any_rty = |s_rty_i_all;

  // A strobe that no slave decodes gets a one-cycle err one cycle later.
  // The flag clears itself, so a held request pulses every other cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dec_err_q <= 1'b0;
    else       dec_err_q <= active && (s_sel_one_hot == '0) && !dec_err_q;
  end

  assign m_ack_o_all = g & {M{any_ack}};
  assign m_rty_o_all = g & {M{any_rty}};
  assign m_err_o_all = g & {M{any_err | dec_err_q | timeout_hit}};
  assign snoop_en_o  = any_ack & gnt_stb & gnt_we;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef WISHBONE_ARB_BUS_TIMEOUT_EN
  logic [TOw-1:0] to_cnt_q;
  logic           term;

  assign term        = any_ack | any_err | any_rty | dec_err_q;
  assign timeout_hit = active && (to_cnt_q == TOw'(TIMEOUT));

  // g only changes after the owner drops cyc. That leaves active low, which
  // already clears the count, so a grant change needs no separate clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            to_cnt_q <= '0;
    else if (!active || term || timeout_hit) to_cnt_q <= '0;
    else                                  to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus_timeout_o = timeout_hit;

endmodule

// File: tb/tb_wishbone_arb_bus.sv
// -----------------------------------------------------------------------------
// tb_wishbone_arb_bus
//
// Drives two instances from the same stimulus: dut 0 is round-robin and
// dut 1 is fixed priority. Both are built with TIMEOUT=4. The directed steps
// cover reset, grant/handover, both arbitration modes, a write with snoop,
// simultaneous terminations, decode error, the watchdog and a mid-burst reset.
// -----------------------------------------------------------------------------
module tb_wishbone_arb_bus;
  localparam int M = 4, S = 4, DW = 32, AW = 32;
  localparam int SELW = 4, TAGW = 3, CTIW = 3, BTEW = 2;
`ifdef WISHBONE_ARB_BUS_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // shared inputs
  logic [M*AW-1:0]   m_adr;
  logic [M*DW-1:0]   m_dat;
  logic [M*SELW-1:0] m_sel;
  logic [M*TAGW-1:0] m_tag;
  logic [M*CTIW-1:0] m_cti;
  logic [M*BTEW-1:0] m_bte;
  logic [M-1:0]      m_we, m_stb, m_cyc;
  logic [S*DW-1:0]   s_dat;
  logic [S-1:0]      s_ack, s_err, s_rty, s_sel;

  // per-instance outputs
  logic [M*DW-1:0]   m_dat_o [2];
  logic [M-1:0]      m_ack_o [2], m_err_o [2], m_rty_o [2];
  logic [S*AW-1:0]   s_adr_o [2];
  logic [S*DW-1:0]   s_dat_o [2];
  logic [S*SELW-1:0] s_sel_o [2];
  logic [S*TAGW-1:0] s_tag_o [2];
  logic [S*CTIW-1:0] s_cti_o [2];
  logic [S*BTEW-1:0] s_bte_o [2];
  logic [S-1:0]      s_we_o [2], s_cyc_o [2], s_stb_o [2];
  logic [AW-1:0]     gnt_addr [2], snoop_adr [2];
  logic              snoop_en [2], bus_to [2], arb_state [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    wishbone_arb_bus #(
      .M(M), .S(S), .Dw(DW), .Aw(AW), .SELw(SELW), .TAGw(TAGW), .CTIw(CTIW),
      .BTEw(BTEW), .ARB_MODE(d), .TOw(8), .TIMEOUT(4)
    ) dut (
      .clk(clk), .reset(reset),
      .m_adr_i_all(m_adr), .m_dat_i_all(m_dat), .m_sel_i_all(m_sel),
      .m_tag_i_all(m_tag), .m_cti_i_all(m_cti), .m_bte_i_all(m_bte),
      .m_we_i_all(m_we), .m_stb_i_all(m_stb), .m_cyc_i_all(m_cyc),
      .m_dat_o_all(m_dat_o[d]), .m_ack_o_all(m_ack_o[d]),
      .m_err_o_all(m_err_o[d]), .m_rty_o_all(m_rty_o[d]),
      .s_adr_o_all(s_adr_o[d]), .s_dat_o_all(s_dat_o[d]), .s_sel_o_all(s_sel_o[d]),
      .s_tag_o_all(s_tag_o[d]), .s_cti_o_all(s_cti_o[d]), .s_bte_o_all(s_bte_o[d]),
      .s_we_o_all(s_we_o[d]), .s_cyc_o_all(s_cyc_o[d]), .s_stb_o_all(s_stb_o[d]),
      .s_dat_i_all(s_dat), .s_ack_i_all(s_ack), .s_err_i_all(s_err),
      .s_rty_i_all(s_rty), .s_sel_one_hot(s_sel),
      .m_grant_addr(gnt_addr[d]), .snoop_adr_o(snoop_adr[d]),
      .snoop_en_o(snoop_en[d]), .bus_timeout_o(bus_to[d]),
      .arb_state_o(arb_state[d])
    );
  end

  // scoreboard counters
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: advance one clock, settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [TAGW-1:0] tags [M];
  logic [AW-1:0]   rr_exp [3];

  initial begin
    // idle inputs, per-master identifying fields
    m_we = '0; m_stb = '0; m_cyc = '0;
    s_dat = '0; s_ack = '0; s_err = '0; s_rty = '0; s_sel = '0;
    m_sel = '1; m_cti = '0; m_bte = '0;
    for (int i = 0; i < M; i++) begin
      m_adr[i*AW +: AW] = AW'(32'h1000 * (i + 1));
      m_dat[i*DW +: DW] = DW'(32'hD000_0000 + i);
      tags[i] = TAGW'($urandom_range(0, 7));
      m_tag[i*TAGW +: TAGW] = tags[i];
    end

    // reset state
    tick(); tick();
    chk("rst_s_cyc", 64'(s_cyc_o[0]), 64'h0);
    chk("rst_s_stb", 64'(s_stb_o[0]), 64'h0);
    chk("rst_m_ack", 64'(m_ack_o[0]), 64'h0);
    chk("rst_state", 64'(arb_state[0]), 64'h0);
    chk("rst_bus_to", 64'(bus_to[0]), 64'h0);
    reset = 1'b0;

    // masters 0 and 2 request together -> master 0, then master 2
    m_cyc = 4'b0101;
    tick();
    chk("rr_first_gnt", 64'(gnt_addr[0]), 64'h1000);
    chk("fx_first_gnt", 64'(gnt_addr[1]), 64'h1000);
    chk("s_cyc_repl", 64'(s_cyc_o[0]), 64'hF);
    chk("s_tag_gnt0", 64'(s_tag_o[0][TAGW-1:0]), 64'(tags[0]));
    m_cyc = 4'b0100;
    #1;
    chk("s_cyc_released", 64'(s_cyc_o[0]), 64'h0);
    tick();
    chk("rr_handover", 64'(gnt_addr[0]), 64'h3000);
    chk("fx_handover", 64'(gnt_addr[1]), 64'h3000);
    chk("s_tag_gnt2", 64'(s_tag_o[0][S*TAGW-1 -: TAGW]), 64'(tags[2]));

    // masters 1 and 3 contend: round-robin pointer sits at 3 after granting 2
    m_cyc = 4'b1010;
    tick();
    chk("rr_13_first", 64'(gnt_addr[0]), 64'h4000);
    chk("fx_13_first", 64'(gnt_addr[1]), 64'h2000);
    rr_exp[0] = 32'h2000; rr_exp[1] = 32'h4000; rr_exp[2] = 32'h2000;
    for (int r = 0; r < 3; r++) begin
      m_cyc = 4'b0000;
      tick();
      chk("idle_state", 64'(arb_state[0]), 64'h0);
      m_cyc = 4'b1010;
      tick();
      chk("rr_13_round", 64'(gnt_addr[0]), 64'(rr_exp[r]));
      chk("fx_13_round", 64'(gnt_addr[1]), 64'h2000);
    end

    // granted write from master 1 to slave 1 (both instances hold master 1)
    m_cyc = 4'b0010; m_stb = 4'b0010; m_we = 4'b0010; s_sel = 4'b0010;
    #1;
    chk("wr_s_stb", 64'(s_stb_o[0]), 64'h2);
    chk("wr_s_dat", 64'(s_dat_o[0][DW-1:0]), 64'hD000_0001);
    chk("wr_no_ack", 64'(m_ack_o[0]), 64'h0);
    chk("wr_no_snoop", 64'(snoop_en[0]), 64'h0);
    s_ack = 4'b0010; s_dat[1*DW +: DW] = 32'h1234_5678;
    #1;
    chk("wr_m_ack", 64'(m_ack_o[0]), 64'h2);
    chk("wr_snoop_en", 64'(snoop_en[0]), 64'h1);
    chk("wr_snoop_adr", 64'(snoop_adr[0]), 64'h2000);
    chk("rd_bcast", 64'(m_dat_o[0][M*DW-1 -: DW]), 64'h1234_5678);
    tick();
    s_ack = 4'b0000;
    #1;
    chk("snoop_drop", 64'(snoop_en[0]), 64'h0);

    // simultaneous terminations all pass through
    s_ack = 4'b0010; s_err = 4'b0010; s_rty = 4'b0010;
    #1;
    chk("sim_ack", 64'(m_ack_o[0]), 64'h2);
    chk("sim_err", 64'(m_err_o[0]), 64'h2);
    chk("sim_rty", 64'(m_rty_o[0]), 64'h2);
    tick();
    s_ack = '0; s_err = '0; s_rty = '0;

    // decode error: no slave selected
    s_sel = 4'b0000;
    #1;
    chk("dec_no_err_yet", 64'(m_err_o[0]), 64'h0);
    chk("dec_no_s_stb", 64'(s_stb_o[0]), 64'h0);
    chk("dec_dat_zero", 64'(m_dat_o[0][DW-1:0]), 64'h0);
    tick();
    chk("dec_err_pulse", 64'(m_err_o[0]), 64'h2);
    chk("dec_err_pulse_fx", 64'(m_err_o[1]), 64'h2);
    tick();
    chk("dec_err_clear", 64'(m_err_o[0]), 64'h0);
    m_cyc = '0; m_stb = '0; m_we = '0; s_sel = 4'b0001;
    tick();

    // watchdog: slave 0 selected, never terminates
    m_cyc = 4'b0010; m_stb = 4'b0010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to_quiet", 64'(bus_to[0]), 64'h0);
    end
    tick();
    chk("to_fifth", 64'(bus_to[0]), 64'(EXP_TO));
    chk("to_err", 64'(m_err_o[0]), EXP_TO ? 64'h2 : 64'h0);
    tick();
    chk("to_after", 64'(bus_to[0]), 64'h0);

    // reset mid-burst abandons the transfer; pending request wins afterwards
    s_ack = 4'b0001;
    #1;
    chk("burst_ack", 64'(m_ack_o[0]), 64'h2);
    m_cyc = 4'b0100; m_stb = 4'b0100;
    reset = 1'b1;
    #1;
    chk("mid_rst_s_stb", 64'(s_stb_o[0]), 64'h0);
    chk("mid_rst_s_cyc", 64'(s_cyc_o[0]), 64'h0);
    chk("mid_rst_m_ack", 64'(m_ack_o[0]), 64'h0);
    chk("mid_rst_state", 64'(arb_state[1]), 64'h0);
    s_ack = '0;
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_idle", 64'(s_cyc_o[0]), 64'h0);
    tick();
    chk("post_rst_gnt_rr", 64'(gnt_addr[0]), 64'h3000);
    chk("post_rst_gnt_fx", 64'(gnt_addr[1]), 64'h3000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
